// File: rtl/serial_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_receiver_pkg
// Description : Shared state encodings and sizing helpers for the serial
//               receiver and its sampler.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_receiver_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_START  = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
  localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
  localparam logic [STATE_W-1:0] ST_STOP   = 3'd4;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

  // Width of the per-bit clock counter for a given divisor.
  function automatic int unsigned cnt_width(input int unsigned divisor);
    return clog2_min1(divisor);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_receiver_sampler.sv
`default_nettype none
// ============================================================================
// Module      : serial_receiver_sampler
// Description : Line synchroniser, per-bit divisor counter and sample-point
//               strobe. With SERIAL_RECEIVER_MAJORITY_EN defined the sampled
//               bit is a 2-of-3 vote around the nominal sample point and the
//               strobe fires one clock later.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_receiver_sampler
  import serial_receiver_pkg::*;
#(
  parameter int unsigned DIVISOR = 16
) (
  input  logic clk,
  input  logic rst_x,
  input  logic i_rx,
  input  logic i_load,
  input  logic i_run,
  output logic o_s,
  output logic o_strobe,
  output logic o_bit
);

  localparam int unsigned CNT_W = cnt_width(DIVISOR);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIVISOR - 1);
`ifdef SERIAL_RECEIVER_MAJORITY_EN
  // The vote needs the clock after the nominal sample point.
  localparam logic [CNT_W-1:0] C_SAMPLE = CNT_W'(DIVISOR / 2 + 1);
`else
  localparam logic [CNT_W-1:0] C_SAMPLE = CNT_W'(DIVISOR / 2);
`endif

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next values for the synchroniser and the bit-period counter; loading to 1
  // puts the counter in phase with the start-edge cycle.
  always_comb begin
    sync1_d = i_rx;
    sync2_d = sync1_q;
    if (i_load) begin
      cnt_d = CNT_W'(1);
    end else if (!i_run) begin
      cnt_d = '0;
    end else if (cnt_q == C_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchroniser flops idle high; counter cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst_x) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SERIAL_RECEIVER_MAJORITY_EN
  logic hist1_q, hist1_d;
  logic hist2_q, hist2_d;

  // Two-deep history of the synchronised line for the vote.
  always_comb begin
    hist1_d = sync2_q;
    hist2_d = hist1_q;
  end

  // History register, idle high like the synchroniser.
  always_ff @(posedge clk) begin
    if (!rst_x) begin
      hist1_q <= 1'b1;
      hist2_q <= 1'b1;
    end else begin
      hist1_q <= hist1_d;
      hist2_q <= hist2_d;
    end
  end

  assign o_bit = (hist2_q & hist1_q) | (hist2_q & sync2_q) | (hist1_q & sync2_q);
`else
  assign o_bit = sync2_q;
`endif

  assign o_s      = sync2_q;
  assign o_strobe = i_run && (cnt_q == C_SAMPLE);

endmodule
`default_nettype wire

// File: rtl/serial_receiver.sv
`default_nettype none
// ============================================================================
// Module      : serial_receiver
// Description : UART-style receiver: start, WIDTH data bits LSB first, one raw
//               parity bit, one stop bit, fixed DIVISOR clocks per bit.
//               Optional feature macro: SERIAL_RECEIVER_MAJORITY_EN (2-of-3
//               vote at each sample point, all events one clock later).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_receiver
  import serial_receiver_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DIVISOR = 16
) (
  input  logic             clk,
  input  logic             rst_x,
  input  logic             i_rx,
  output logic [WIDTH-1:0] o_data,
  output logic             o_parity,
  output logic             o_valid,
  output logic             o_frame_error,
  output logic             o_busy
);

  localparam int unsigned IDX_W = clog2_min1(WIDTH);
  localparam logic [IDX_W-1:0] C_LAST_BIT = IDX_W'(WIDTH - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic               par_q, par_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               parity_q, parity_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;

  logic w_s, w_strobe, w_bit, w_load, w_run;

  serial_receiver_sampler #(
    .DIVISOR (DIVISOR)
  ) u_sampler (
    .clk      (clk),
    .rst_x    (rst_x),
    .i_rx     (i_rx),
    .i_load   (w_load),
    .i_run    (w_run),
    .o_s      (w_s),
    .o_strobe (w_strobe),
    .o_bit    (w_bit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_x) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: every transition after IDLE waits for a sample strobe.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!w_s) state_d = ST_START;
      ST_START:  if (w_strobe) state_d = w_bit ? ST_IDLE : ST_DATA;
      ST_DATA:   if (w_strobe && (bit_idx_q == C_LAST_BIT)) state_d = ST_PARITY;
      ST_PARITY: if (w_strobe) state_d = ST_STOP;
      ST_STOP:   if (w_strobe) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs. The FSM is already back in IDLE during the o_valid cycle so a
  // back-to-back start edge is caught there; busy is stretched over that cycle.
  always_comb begin
    w_load = (state_q == ST_IDLE) && !w_s;
    w_run  = (state_q != ST_IDLE);
    o_busy = (state_q != ST_IDLE) || valid_q;
  end

  // Datapath: shift data LSB first, capture parity, publish on the stop sample.
  always_comb begin
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    data_d    = data_q;
    parity_d  = parity_q;
    ferr_d    = ferr_q;
    valid_d   = 1'b0;
    if (w_strobe) begin
      case (state_q)
        ST_START: begin
          bit_idx_d = '0;
        end
        ST_DATA: begin
          shift_d            = shift_q >> 1;
          shift_d[WIDTH-1]   = w_bit;
          bit_idx_d          = bit_idx_q + 1'b1;
        end
        ST_PARITY: begin
          par_d = w_bit;
        end
        ST_STOP: begin
          valid_d  = 1'b1;
          data_d   = shift_q;
          parity_d = par_q;
          ferr_d   = ~w_bit;
        end
        default: begin
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // Datapath and output registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (!rst_x) begin
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      data_q    <= '0;
      parity_q  <= 1'b0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign o_data        = data_q;
  assign o_parity      = parity_q;
  assign o_valid       = valid_q;
  assign o_frame_error = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_serial_receiver
// Description : Directed self-checking bench for serial_receiver with
//               WIDTH=8, DIVISOR=4 (4 clocks per line bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_receiver;

  logic       clk = 1'b0;
  logic       rst_x = 1'b0;
  logic       i_rx = 1'b1;
  logic [7:0] o_data;
  logic       o_parity;
  logic       o_valid;
  logic       o_frame_error;
  logic       o_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

`ifdef SERIAL_RECEIVER_MAJORITY_EN
  localparam int M = 1;
  localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
  localparam int M = 0;
  localparam logic [7:0] GLITCH_EXP = 8'h04;
`endif
  // Line goes low in cycle 0; s follows at cycle 2 (T); stop sample at
  // T+2+10*4 = 44; o_valid one cycle later = 45 (+1 with the vote).
  localparam int LAT = 45 + M;

  serial_receiver #(
    .WIDTH   (8),
    .DIVISOR (4)
  ) dut (
    .clk           (clk),
    .rst_x         (rst_x),
    .i_rx          (i_rx),
    .o_data        (o_data),
    .o_parity      (o_parity),
    .o_valid       (o_valid),
    .o_frame_error (o_frame_error),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every o_valid pulse with its cycle number.
  int         vcyc[$];
  logic [7:0] vdata[$];
  logic       vpar[$];
  logic       vfe[$];
  logic       vbusy[$];

  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      vcyc.push_back(cyc);
      vdata.push_back(o_data);
      vpar.push_back(o_parity);
      vfe.push_back(o_frame_error);
      vbusy.push_back(o_busy);
    end
  end

  logic [7:0] snap_data  = 8'hFF;
  logic       snap_par   = 1'b1;
  logic       snap_fe    = 1'b1;
  logic       snap_busy  = 1'b1;
  logic       snap_valid = 1'b1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    vcyc.delete();
    vdata.delete();
    vpar.delete();
    vfe.delete();
    vbusy.delete();
  endtask

  // Drive one 11-bit frame, 4 clocks per bit. Optionally invert the line for
  // one clock (glitch) and/or pulse rst_x low for one clock (rst_at); the
  // outputs are snapshot in the clock after the reset pulse.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic st,
                            input int glitch, input int rst_at);
    logic [10:0] fr;
    fr = {st, p, d, 1'b0};
    for (int c = 0; c < 44; c++) begin
      i_rx  = fr[c / 4] ^ (c == glitch);
      rst_x = (c == rst_at) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (rst_at >= 0 && c == rst_at + 1) begin
        snap_data  = o_data;
        snap_par   = o_parity;
        snap_fe    = o_frame_error;
        snap_busy  = o_busy;
        snap_valid = o_valid;
      end
      @(posedge clk);
      #1;
    end
    i_rx  = 1'b1;
    rst_x = 1'b1;
  endtask

  int s0;
  int g0;

  initial begin
    // ---- reset state
    rst_x = 1'b0;
    i_rx  = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_data",   o_data, 8'h00);
    chk("rst_parity", o_parity, 1'b0);
    chk("rst_valid",  o_valid, 1'b0);
    chk("rst_ferr",   o_frame_error, 1'b0);
    chk("rst_busy",   o_busy, 1'b0);
    tick();
    rst_x = 1'b1;
    repeat (6) tick();

    // ---- frame 0xA5, parity 0, stop 1
    s0 = cyc;
    send_frame(8'hA5, 1'b0, 1'b1, -1, -1);
    repeat (8) tick();
    chk("a5_count",   vcyc.size(), 1);
    chk("a5_latency", vcyc[0] - s0, LAT);
    chk("a5_data",    vdata[0], 8'hA5);
    chk("a5_parity",  vpar[0], 1'b0);
    chk("a5_ferr",    vfe[0], 1'b0);
    chk("a5_busy_at_valid", vbusy[0], 1'b1);
    @(negedge clk);
    chk("a5_busy_after", o_busy, 1'b0);
    tick();
    clear_q();

    // ---- one-clock low glitch: false start
    g0 = cyc;
    i_rx = 1'b0;
    tick();
    i_rx = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("glitch_busy_t1", o_busy, 1'b1);
    tick();
    repeat (1 + M) tick();
    @(negedge clk);
    chk("glitch_busy_t3", o_busy, 1'b0);
    chk("glitch_busy_cycle", cyc - g0, 5 + M);
    tick();
    repeat (50) tick();
    chk("glitch_no_valid", vcyc.size(), 0);
    clear_q();

    // ---- frame 0x3C, parity 1, stop 0 (framing error)
    send_frame(8'h3C, 1'b1, 1'b0, -1, -1);
    repeat (12) tick();
    chk("3c_count",  vcyc.size(), 1);
    chk("3c_data",   vdata[0], 8'h3C);
    chk("3c_parity", vpar[0], 1'b1);
    chk("3c_ferr",   vfe[0], 1'b1);
    clear_q();
    repeat (8) tick();

    // ---- back-to-back 0x01 then 0xFE
    s0 = cyc;
    send_frame(8'h01, 1'b1, 1'b1, -1, -1);
    send_frame(8'hFE, 1'b1, 1'b1, -1, -1);
    repeat (8) tick();
    chk("b2b_count",   vcyc.size(), 2);
    chk("b2b_latency", vcyc[0] - s0, LAT);
    chk("b2b_spacing", vcyc[1] - vcyc[0], 44);
    chk("b2b_data0",   vdata[0], 8'h01);
    chk("b2b_data1",   vdata[1], 8'hFE);
    chk("b2b_ferr1",   vfe[1], 1'b0);
    clear_q();

    // ---- reset pulse during data bit 4, then 0x55
    send_frame(8'hFF, 1'b1, 1'b1, -1, 21);
    chk("mrst_data",   snap_data, 8'h00);
    chk("mrst_parity", snap_par, 1'b0);
    chk("mrst_ferr",   snap_fe, 1'b0);
    chk("mrst_busy",   snap_busy, 1'b0);
    chk("mrst_valid",  snap_valid, 1'b0);
    repeat (12) tick();
    chk("mrst_no_valid", vcyc.size(), 0);
    clear_q();
    s0 = cyc;
    send_frame(8'h55, 1'b0, 1'b1, -1, -1);
    repeat (8) tick();
    chk("55_count",   vcyc.size(), 1);
    chk("55_latency", vcyc[0] - s0, LAT);
    chk("55_data",    vdata[0], 8'h55);
    chk("55_parity",  vpar[0], 1'b0);
    clear_q();

    // ---- 0x00 with a one-clock glitch on the data bit 2 sample point
    send_frame(8'h00, 1'b0, 1'b1, 14, -1);
    repeat (8) tick();
    chk("g2_count", vcyc.size(), 1);
    chk("g2_data",  vdata[0], GLITCH_EXP);
    chk("g2_ferr",  vfe[0], 1'b0);
    clear_q();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
